debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Parametrised N-channel push-button conditioner, successor to the single-channel debouncer.
//  Per channel: 2-FF synchroniser, debounce counter, registered press/release pulses,
//  long-press (hold) level and optional auto-repeat pulse train.
//  Sits between board buttons and game/FSM logic; all outputs synchronous to clk.
// PARAMETERS
//  NUM_CH          4          number of independent button channels (>=1)
//  ACTIVE_LOW      1          1: pb pressed = 0; 0: pb pressed = 1 (applies to all channels)
//  DEBOUNCE_CYCLES 2097152    consecutive mismatch cycles needed to accept a change (>=2)
//  HOLD_CYCLES     50000000   cycles pressed before pb_hold asserts (>DEBOUNCE_CYCLES)
//  REPEAT_CYCLES   10000000   auto-repeat period once held (>=2)
//  REPEAT_EN       1          1: pb_repeat active; 0: pb_repeat tied 0, repeat counters removed
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  pb         in   NUM_CH  raw, glitchy, asynchronous button inputs
//  pb_state   out  NUM_CH  debounced level, 1 = pressed
//  pb_down    out  NUM_CH  1-cycle pulse on accepted press
//  pb_up      out  NUM_CH  1-cycle pulse on accepted release
//  pb_hold    out  NUM_CH  level, 1 while pressed for >= HOLD_CYCLES
//  pb_repeat  out  NUM_CH  1-cycle pulses while held (REPEAT_EN=1)
// BEHAVIOUR
//  - One clock; reset asynchronous, active-high; all regs clear immediately on reset assert.
//  - Reset values: pb_state=pb_down=pb_up=pb_hold=pb_repeat=0; all counters 0; synchroniser
//    FFs reset to "not pressed" (post-polarity 0). Reset mid-press: no pulse on deassert;
//    a still-pressed button is re-accepted as a fresh press after normal debounce latency.
//  - Polarity: act = ACTIVE_LOW ? ~pb : pb, then sync0 <= act, sync1 <= sync0.
//  - Debounce per channel: if sync1==pb_state, cnt<=0; else cnt<=cnt+1. On the edge where
//    cnt==DEBOUNCE_CYCLES-1 and mismatch still sampled: pb_state<=~pb_state, cnt<=0.
//    Any single matching sample clears cnt (glitch shorter than DEBOUNCE_CYCLES is rejected).
//  - Latency: stable pb change just before edge 0 -> pb_state flips at edge DEBOUNCE_CYCLES+1.
//  - pb_down/pb_up are registered: high for exactly the cycle after the flip edge, i.e.
//    coincident with the first cycle of the new pb_state. Never both high; never high in reset.
//  - cnt width = $clog2(DEBOUNCE_CYCLES); no wrap possible (cleared at terminal value).
//  - Hold: hcnt cleared while pb_state=0; increments while pb_state=1, saturates at HOLD_CYCLES.
//    pb_hold = registered (hcnt==HOLD_CYCLES); rises HOLD_CYCLES cycles after pb_state rises;
//    falls on the same edge pb_state falls. hcnt never wraps.
//  - Repeat (REPEAT_EN=1): first pb_repeat pulse on the cycle pb_hold first rises; then one
//    pulse every REPEAT_CYCLES cycles while pb_hold=1; rcnt cleared when pb_hold=0.
//    Release edge cancels any pending pulse (no pb_repeat in the pb_up cycle or after).
//  - Channels fully independent; simultaneous events on several channels all reported
//    in the same cycle. pb_down and a pb_up on other channels may coincide.
//  - No combinational path from pb to any output.
// TESTING (bench params: NUM_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8)
//  1 ACTIVE_LOW=1, ch0 pb 1->0 held -> pb_state[0]=1 at edge 5, pb_down[0]=1 one cycle,
//    others 0.
//  2 ch1 bounce: low 3 cycles, high 1, low stable -> exactly one pb_down[1],
//    edge 5 after final fall.
//  3 ch2 held 40 cycles after accept -> pb_hold[2] rises 16 cycles after pb_state;
//    pb_repeat pulses at +16,+24,+32,+40.
//  4 release during hold -> pb_up one cycle; pb_hold, pb_repeat 0 from that edge;
//    no extra pulses.
//  5 all 4 channels pressed same cycle -> pb_down=4'b1111 for one cycle.
//    Release glitch of 3 cycles -> no pb_up.
//  6 reset asserted mid-hold (async, between edges) -> all outputs 0 immediately;
//    button still pressed after deassert -> new pb_down after 5 edges.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel push-button conditioner.
// Each channel has a 2-FF synchroniser, a debounce counter, registered press/release pulses,
// a long-press hold level and an optional auto-repeat pulse train. All outputs are registered.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   pb         raw asynchronous button inputs (polarity set by ACTIVE_LOW)
//   pb_state   debounced level, 1 = pressed
//   pb_down    1-cycle pulse, first cycle of an accepted press
//   pb_up      1-cycle pulse, first cycle of an accepted release
//   pb_hold    1 while pressed for >= HOLD_CYCLES
//   pb_repeat  1-cycle pulses while held (tied 0 when REPEAT_EN = 0)
module debounce_bank #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 2097152,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter int unsigned REPEAT_EN       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pb,
    output logic [NUM_CH-1:0] pb_state,
    output logic [NUM_CH-1:0] pb_down,
    output logic [NUM_CH-1:0] pb_up,
    output logic [NUM_CH-1:0] pb_hold,
    output logic [NUM_CH-1:0] pb_repeat
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

    // Post-polarity button level, 1 = pressed.
    logic [NUM_CH-1:0] act;

    always_comb begin
        act = (ACTIVE_LOW != 0) ? ~pb : pb;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic          sync0_q, sync1_q;
        logic          state_q, state_d;
        logic          down_q, up_q;
        logic          hold_q, hold_d;
        logic          flip;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;

        always_comb begin
            flip    = 1'b0;
            state_d = state_q;
            cnt_d   = '0;
            // Any matching sample leaves cnt_d at 0, which rejects short glitches.
            if (sync1_q != state_q) begin
                if (cnt_q == CNT_MAX) begin
                    flip    = 1'b1;
                    state_d = ~state_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            if (!state_q) begin
                hcnt_d = '0;
            end else if (hcnt_q == HOLD_MAX) begin
                hcnt_d = hcnt_q;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            // Looking at next-state values makes hold rise exactly HOLD_CYCLES after the press
            // edge and drop on the same edge as the release.
            hold_d = state_d && (hcnt_d == HOLD_MAX);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync0_q <= 1'b0;
                sync1_q <= 1'b0;
                state_q <= 1'b0;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                down_q  <= 1'b0;
                up_q    <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                sync0_q <= act[ch];
                sync1_q <= sync0_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hcnt_q  <= hcnt_d;
                down_q  <= flip & ~state_q;
                up_q    <= flip & state_q;
                hold_q  <= hold_d;
            end
        end

        assign pb_state[ch] = state_q;
        assign pb_down[ch]  = down_q;
        assign pb_up[ch]    = up_q;
        assign pb_hold[ch]  = hold_q;

        if (REPEAT_EN != 0) begin : g_rep
            logic          rep_q, rep_d;
            logic [RW-1:0] rcnt_q, rcnt_d;

            always_comb begin
                rep_d  = 1'b0;
                rcnt_d = '0;
                if (hold_d) begin
                    if (!hold_q || (rcnt_q == REP_MAX)) begin
                        // First pulse coincides with hold rising, then once per period.
                        rep_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rep_q  <= 1'b0;
                    rcnt_q <= '0;
                end else begin
                    rep_q  <= rep_d;
                    rcnt_q <= rcnt_d;
                end
            end

            assign pb_repeat[ch] = rep_q;
        end else begin : g_norep
            assign pb_repeat[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of debounce_bank with small counter parameters.
module tb_debounce_bank;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 16;
    localparam int unsigned REP  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] pb;
    logic [NCH-1:0] pb_state, pb_down, pb_up, pb_hold, pb_repeat;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    debounce_bank #(
        .NUM_CH         (NCH),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_EN      (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pb       (pb),
        .pb_state (pb_state),
        .pb_down  (pb_down),
        .pb_up    (pb_up),
        .pb_hold  (pb_hold),
        .pb_repeat(pb_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] all_o();
        return {12'd0, pb_state, pb_down, pb_up, pb_hold, pb_repeat};
    endfunction

    initial begin
        int unsigned downs;
        logic [3:0]  ups;
        logic [3:0]  exp4;

        // Reset
        reset = 1'b1;
        pb    = 4'hF;
        #2;
        check("reset_async", all_o(), 32'd0);
        tick(2);
        check("reset_held", all_o(), 32'd0);
        reset = 1'b0;
        tick(8);
        check("idle", all_o(), 32'd0);

        // 1: ch0 clean press, accepted at edge 5
        pb[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t1_wait%0d", i), {pb_state, pb_down}, 32'd0);
        end
        tick(1);
        check("t1_accept", {pb_state, pb_down, pb_up}, {4'b0001, 4'b0001, 4'b0000});
        tick(1);
        check("t1_pulse_end", {pb_state, pb_down}, {4'b0001, 4'b0000});
        pb[0] = 1'b1;
        tick(5);
        check("t1_rel_wait", {pb_state, pb_up}, {4'b0001, 4'b0000});
        tick(1);
        check("t1_release", {pb_state, pb_down, pb_up}, {4'b0000, 4'b0000, 4'b0001});
        tick(1);
        check("t1_up_end", {pb_state, pb_up}, 32'd0);

        // 2: ch1 bounce, low 3 / high 1 / low stable
        downs = 0;
        pb[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            downs += pb_down[1];
        end
        pb[1] = 1'b1;
        tick(1);
        downs += pb_down[1];
        pb[1] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 5) check("t2_no_early", {downs[3:0], pb_state[1]}, 32'd0);
            if (i == 6) check("t2_accept", {pb_state[1], pb_down[1]}, 2'b11);
            downs += pb_down[1];
        end
        check("t2_one_down", downs, 32'd1);
        pb[1] = 1'b1;
        tick(10);

        // 3+4: ch2 hold / repeat, then release landing on a would-be repeat slot
        pb[2] = 1'b0;
        tick(6);
        check("t3_accept", {pb_state[2], pb_down[2]}, 2'b11);
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            exp4 = {k < 48, k == 48, (k >= 16) && (k < 48),
                    (k == 16) || (k == 24) || (k == 32) || (k == 40)};
            check($sformatf("t34_k%0d", k), {pb_state[2], pb_up[2], pb_hold[2], pb_repeat[2]},
                  exp4);
            if (k == 42) pb[2] = 1'b1;
        end

        // 5: all channels pressed together, then a 3-cycle release glitch
        pb = 4'h0;
        tick(5);
        check("t5_wait", {pb_state, pb_down}, 32'd0);
        tick(1);
        check("t5_accept", {pb_state, pb_down}, 8'hFF);
        tick(1);
        check("t5_pulse_end", {pb_state, pb_down}, 8'hF0);
        ups = 4'h0;
        pb  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            ups |= pb_up;
        end
        pb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            ups |= pb_up;
        end
        check("t5_glitch_no_up", ups, 32'd0);
        check("t5_state_kept", pb_state, 4'hF);
        tick(2);
        check("t5_hold_rep", {pb_hold, pb_repeat}, 8'hFF);

        // 6: async reset mid-hold, button still pressed afterwards
        tick(2);
        check("t6_pre_hold", {pb_state, pb_hold}, 8'hFF);
        #3;
        reset = 1'b1;
        #1;
        check("t6_reset_immediate", all_o(), 32'd0);
        tick(2);
        check("t6_reset_held", all_o(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t6_wait%0d", i), {pb_state, pb_down, pb_up}, 32'd0);
        end
        tick(1);
        check("t6_reaccept", {pb_state, pb_down, pb_up}, {4'hF, 4'hF, 4'h0});
        tick(1);
        check("t6_pulse_end", {pb_state, pb_down}, 8'hF0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
